// File: rtl/payload_sender.sv
// payload_sender: snapshots a sequence count or external word, writes it
// byte-wise into the tx packet BRAM, then pulses start to the transmitter.
module payload_sender #(
  parameter int                ADDR_W        = 10,
  parameter int                PAYLOAD_BYTES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 10'h038,
  parameter bit                BIG_ENDIAN    = 1'b1,
  parameter bit                SRC_EXT       = 1'b0,
  parameter int                PERIOD_W      = 21,
  parameter int                PERIOD        = 2**21-1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       en,
  input  logic                       trig,
  input  logic [8*PAYLOAD_BYTES-1:0] payload_in,
  input  logic                       tx_busy,
  output logic                       bram_wr_en,
  output logic [ADDR_W-1:0]          bram_wr_addr,
  output logic [7:0]                 bram_wr_data,
  output logic                       start,
  output logic                       busy,
  output logic [31:0]                seq,
  output logic                       overrun
);

  localparam int SW = 8*PAYLOAD_BYTES;
  localparam int IW = 5;
  localparam logic [IW-1:0] NBYTES = IW'(PAYLOAD_BYTES);
  localparam logic [PERIOD_W-1:0] TMR_LAST = PERIOD_W'(PERIOD-1);

  typedef enum logic [1:0] {IDLE, WAIT_TX, WRITE, START} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [SW-1:0]       snap_q, snap_d;
  logic [31:0]         seq_q, seq_d, seq_inc;
  logic                ovr_q, ovr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                fire, trg;

  function automatic logic [7:0] pick(
    input logic [SW-1:0] s,
    input logic [IW-1:0] k
  );
    logic [IW-1:0] b;
    logic [SW-1:0] t;
    b = BIG_ENDIAN ? NBYTES - 1'b1 - k : k;
    t = s >> {b, 3'b000};
    return t[7:0];
  endfunction

  always_comb begin
    fire  = 1'b0;
    tmr_d = '0;
    if (en && PERIOD != 0) begin
      fire  = (tmr_q == TMR_LAST);
      tmr_d = fire ? '0 : tmr_q + 1'b1;
    end
  end

  assign seq_inc = seq_q + 32'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    seq_d   = seq_q;
    ovr_d   = ovr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = 1'b0;
    trg     = fire | trig;
    if (trg && state_q != IDLE) ovr_d = 1'b1;
    unique case (state_q)
      IDLE: if (trg) begin
        snap_d  = SRC_EXT ? payload_in : SW'(seq_inc);
        seq_d   = seq_inc;
        state_d = WAIT_TX;
      end
      WAIT_TX: if (!tx_busy) begin
        idx_d   = '0;
        wr_en_d = 1'b1;
        addr_d  = BASE_ADDR;
        data_d  = pick(snap_q, '0);
        state_d = WRITE;
      end
      // alternate strobe-high and strobe-low ticks per byte
      WRITE: begin
        if (wr_en_q) begin
          idx_d = idx_q + 1'b1;
        end else if (idx_q == NBYTES) begin
          start_d = 1'b1;
          state_d = START;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = BASE_ADDR + ADDR_W'(idx_q);
          data_d  = pick(snap_q, idx_q);
        end
      end
      START:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seq_q   <= '0;
      ovr_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seq_q   <= seq_d;
      ovr_q   <= ovr_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = addr_q;
  assign bram_wr_data = data_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign seq          = seq_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_payload_sender.sv
// tb_payload_sender: two payload_sender configs against a timeline model
// of packet events (trigger, tx release, byte slots, start).
module tb_payload_sender;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, en, trig, tx_busy;
  logic [31:0] payload_in;

  logic        wr_a, st_a, bsy_a, ov_a;
  logic [9:0]  addr_a;
  logic [7:0]  data_a;
  logic [31:0] seq_a;
  logic        wr_b, st_b, bsy_b, ov_b;
  logic [9:0]  addr_b;
  logic [7:0]  data_b;
  logic [31:0] seq_b;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int nst_b = 0;

  logic [17:0] qa[$];
  logic [17:0] qb[$];

  bit          m_act[2], m_wait[2];
  int          m_w[2], m_tmr[2];
  logic [31:0] m_snap[2], m_seq[2];
  bit          m_ovr[2], e_wr[2], e_st[2];
  logic [9:0]  e_addr[2];
  logic [7:0]  e_data[2];

  always #5 clk = ~clk;

  payload_sender #(
    .ADDR_W(10), .PAYLOAD_BYTES(NB), .BASE_ADDR(10'h038),
    .BIG_ENDIAN(1'b1), .SRC_EXT(1'b0), .PERIOD_W(21), .PERIOD(32)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en),
    .trig(trig), .payload_in(payload_in), .tx_busy(tx_busy),
    .bram_wr_en(wr_a), .bram_wr_addr(addr_a),
    .bram_wr_data(data_a), .start(st_a), .busy(bsy_a),
    .seq(seq_a), .overrun(ov_a)
  );

  payload_sender #(
    .ADDR_W(10), .PAYLOAD_BYTES(NB), .BASE_ADDR(10'h3FE),
    .BIG_ENDIAN(1'b0), .SRC_EXT(1'b1), .PERIOD_W(21), .PERIOD(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en),
    .trig(trig), .payload_in(payload_in), .tx_busy(tx_busy),
    .bram_wr_en(wr_b), .bram_wr_addr(addr_b),
    .bram_wr_data(data_b), .start(st_b), .busy(bsy_b),
    .seq(seq_b), .overrun(ov_b)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_wait[d] = 0; m_w[d] = 0; m_tmr[d] = 0;
      m_snap[d] = '0; m_seq[d] = '0; m_ovr[d] = 0;
      e_wr[d] = 0; e_st[d] = 0; e_addr[d] = '0; e_data[d] = '0;
    end
  endtask

  // unit 0: BE, seq payload, PERIOD 32; unit 1: LE, ext payload, no timer
  task automatic model_step(int d);
    bit fire, trg, act;
    int per, k, j;
    per = (d == 1) ? 0 : 32;
    fire = 0;
    if (en && per != 0) begin
      fire = (m_tmr[d] == per - 1);
      m_tmr[d] = fire ? 0 : m_tmr[d] + 1;
    end else begin
      m_tmr[d] = 0;
    end
    trg = fire || trig;
    act = m_act[d];
    if (!act && trg) begin
      m_snap[d] = (d == 1) ? payload_in : m_seq[d] + 32'd1;
      m_seq[d] = m_seq[d] + 32'd1;
      m_act[d] = 1;
      m_wait[d] = 1;
    end else if (act && trg) begin
      m_ovr[d] = 1;
    end
    if (act) begin
      if (m_wait[d]) begin
        if (!tx_busy) begin
          m_wait[d] = 0;
          m_w[d] = ecnt;
        end
      end else if (ecnt - m_w[d] == 2*NB + 1) begin
        m_act[d] = 0;
      end
    end
    e_wr[d] = 0;
    e_st[d] = 0;
    k = ecnt - m_w[d];
    if (m_act[d] && !m_wait[d]) begin
      if (k < 2*NB && k % 2 == 0) begin
        j = k / 2;
        e_wr[d] = 1;
        if (d == 1) begin
          e_addr[d] = 10'(32'h3FE + j);
          e_data[d] = 8'(m_snap[d] >> (8*j));
        end else begin
          e_addr[d] = 10'(32'h038 + j);
          e_data[d] = 8'(m_snap[d] >> (8*(NB-1-j)));
        end
      end
      if (k == 2*NB) e_st[d] = 1;
    end
  endtask

  task automatic cmp_all();
    chk("A.wr_en", 32'(wr_a), 32'(e_wr[0]));
    chk("A.addr", 32'(addr_a), 32'(e_addr[0]));
    chk("A.data", 32'(data_a), 32'(e_data[0]));
    chk("A.start", 32'(st_a), 32'(e_st[0]));
    chk("A.busy", 32'(bsy_a), 32'(m_act[0]));
    chk("A.seq", seq_a, m_seq[0]);
    chk("A.overrun", 32'(ov_a), 32'(m_ovr[0]));
    chk("B.wr_en", 32'(wr_b), 32'(e_wr[1]));
    chk("B.addr", 32'(addr_b), 32'(e_addr[1]));
    chk("B.data", 32'(data_b), 32'(e_data[1]));
    chk("B.start", 32'(st_b), 32'(e_st[1]));
    chk("B.busy", 32'(bsy_b), 32'(m_act[1]));
    chk("B.seq", seq_b, m_seq[1]);
    chk("B.overrun", 32'(ov_b), 32'(m_ovr[1]));
  endtask

  task automatic cyc();
    bit tk;
    @(posedge clk);
    tk = rst_n && clk_en;
    if (tk) begin
      model_step(0);
      model_step(1);
      ecnt++;
    end
    #1;
    cmp_all();
    if (tk) begin
      if (wr_a) qa.push_back({addr_a, data_a});
      if (wr_b) qb.push_back({addr_b, data_b});
      if (st_b) nst_b++;
    end
  endtask

  task automatic chk_zero(string p);
    chk({p, ".rst_wr"}, 32'(p == "A" ? wr_a : wr_b), 0);
    chk({p, ".rst_st"}, 32'(p == "A" ? st_a : st_b), 0);
    chk({p, ".rst_busy"}, 32'(p == "A" ? bsy_a : bsy_b), 0);
    chk({p, ".rst_addr"}, 32'(p == "A" ? addr_a : addr_b), 0);
    chk({p, ".rst_data"}, 32'(p == "A" ? data_a : data_b), 0);
    chk({p, ".rst_seq"}, p == "A" ? seq_a : seq_b, 0);
  endtask

  initial begin
    rst_n = 0; clk_en = 1; en = 0; trig = 0; tx_busy = 0;
    payload_in = '0;
    model_reset();
    repeat (3) cyc();
    chk_zero("A");
    chk_zero("B");
    rst_n = 1;

    // periodic packets from the sequence counter
    en = 1;
    repeat (80) cyc();
    chk("A.nwrites", qa.size(), 8);
    if (qa.size() >= 8) begin
      chk("A.p1b0", 32'(qa[0]), 32'h03800);
      chk("A.p1b1", 32'(qa[1]), 32'h03900);
      chk("A.p1b2", 32'(qa[2]), 32'h03A00);
      chk("A.p1b3", 32'(qa[3]), 32'h03B01);
      chk("A.p2b3", 32'(qa[7]), 32'h03B02);
    end
    chk("A.seq2", seq_a, 2);

    // manual trigger, payload change mid-burst, overrun retrigger
    en = 0;
    qa.delete(); qb.delete(); nst_b = 0;
    payload_in = 32'hA1B2C3D4;
    trig = 1; cyc(); trig = 0;
    payload_in = 32'h11223344;
    repeat (2) cyc();
    trig = 1; cyc(); trig = 0;
    repeat (15) cyc();
    chk("B.nwrites", qb.size(), 4);
    if (qb.size() >= 4) begin
      chk("B.w0", 32'(qb[0]), {14'd0, 10'h3FE, 8'hD4});
      chk("B.w1", 32'(qb[1]), {14'd0, 10'h3FF, 8'hC3});
      chk("B.w2", 32'(qb[2]), {14'd0, 10'h000, 8'hB2});
      chk("B.w3", 32'(qb[3]), {14'd0, 10'h001, 8'hA1});
    end
    chk("B.nstart", nst_b, 1);
    chk("B.seq1", seq_b, 1);
    chk("B.ovr", 32'(ov_b), 1);
    chk("A.seq3", seq_a, 3);

    // transmitter-busy hold
    qb.delete();
    tx_busy = 1;
    trig = 1; cyc(); trig = 0;
    repeat (20) cyc();
    chk("hold.nowr", qb.size(), 0);
    tx_busy = 0;
    cyc();
    chk("hold.first_wr", 32'(wr_b), 1);
    repeat (12) cyc();

    // randomized traffic, first part at quarter clk_en duty
    en = 1;
    for (int n = 0; n < 3000; n++) begin
      clk_en = (n < 1200) ? ($urandom_range(3) == 0) : 1'b1;
      trig = ($urandom_range(25) == 0);
      tx_busy = ($urandom_range(3) == 0);
      payload_in = $urandom;
      if (n > 2000) en = ($urandom_range(7) != 0);
      cyc();
    end

    // reset in the middle of a burst
    clk_en = 1; en = 0; trig = 0; tx_busy = 0;
    repeat (20) cyc();
    trig = 1; cyc(); trig = 0;
    repeat (3) cyc();
    chk("mid.wr_b1", 32'(wr_b), 1);
    #2 rst_n = 0;
    #1;
    chk_zero("A");
    chk_zero("B");
    model_reset();
    repeat (2) cyc();
    rst_n = 1;
    nst_b = 0;
    repeat (6) cyc();
    chk("post.nostart", nst_b, 0);
    payload_in = 32'h5A5A0001;
    trig = 1; cyc(); trig = 0;
    repeat (12) cyc();
    chk("post.seqA", seq_a, 1);
    chk("post.seqB", seq_b, 1);
    chk("post.nstart", nst_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
